bus_arbiter: RTL

Shared-bus arbiter and slave decoder sitting directly downstream of the core's data-bus master port. It consumes each master's `req_out`, grants the bus to one master at a time by driving its `select_as_in` to master mode, stalls losers through `bus_hold_flag_in`, and puts the addressed slave into device mode. A one-cycle turnaround between grants keeps the tri-state address, data and rw lines from being driven by two agents at once.

---
 rtl/bus_arbiter_pkg.sv | 25 ++
 rtl/bus_arbiter_picker.sv | 30 +++
 rtl/bus_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: select-mode codes, FSM state encoding, bus widths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bus_arbiter_pkg;

  // Width of the shared memory address bus tapped by the slave decoder.
  localparam int MemAddressBusWidth = 32;

  // Width of one per-agent select-mode field.
  localparam int SelectModeBus = 2;

  // Select-mode codes driven onto master and slave select_as inputs.
  localparam logic [SelectModeBus-1:0] SelectAsNone   = 2'b00;
  localparam logic [SelectModeBus-1:0] SelectAsMaster = 2'b01;
  localparam logic [SelectModeBus-1:0] SelectAsDevice = 2'b10;

  // Arbiter FSM encoding.
  localparam int ArbStateBus = 2;
  typedef enum logic [ArbStateBus-1:0] {
    ArbIdle  = 2'b00,
    ArbGrant = 2'b01,
    ArbTurn  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_picker.sv
// Round-robin priority picker: first set request at or after rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; winner_vld low when no request is pending.
module rr_priority_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req_in,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       winner_idx,
  output logic                   winner_vld
);

  logic [IDX_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest requester overwrites the others.
  always_comb begin
    winner_idx = '0;
    winner_vld = 1'b0;
    cand       = '0;
    for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(rr_ptr) + off) % NUM_MASTERS);
      if (req_in[cand]) begin
        winner_idx = cand;
        winner_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter + slave decoder; optional grant timeout under BUS_ARB_TIMEOUT_EN.
// Latency: request to grant 1 cycle from IDLE; release to next grant 2 cycles via TURN.
// Backpressure: losing requesters are stalled combinationally through hold_flag_out.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 4,
  parameter int SLAVE_SEL_BITS = 2,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_MASTERS-1:0]                     req_in,
  input  logic [MemAddressBusWidth-1:0]              addr_in,
  output logic [NUM_MASTERS-1:0][SelectModeBus-1:0]  master_select_as_out,
  output logic [NUM_SLAVES-1:0][SelectModeBus-1:0]   slave_select_as_out,
  output logic [NUM_MASTERS-1:0]                     hold_flag_out,
  output logic [IDX_W-1:0]                           grant_idx_out,
  output logic                                       bus_busy_out,
  output logic                                       timeout_out
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] grant_idx, grant_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic [IDX_W-1:0] ptr_after_owner;
  logic [SLAVE_SEL_BITS-1:0] slave_idx;
  logic             unused_addr;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tmo_q, tmo_nxt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req_in     (req_in),
    .rr_ptr     (rr_ptr),
    .winner_idx (pick_idx),
    .winner_vld (pick_vld)
  );

  assign ptr_after_owner = (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + IDX_W'(1);
  assign slave_idx       = addr_in[MemAddressBusWidth-1 -: SLAVE_SEL_BITS];
  assign unused_addr     = ^addr_in[MemAddressBusWidth-SLAVE_SEL_BITS-1:0];

  // State, owner, round-robin pointer and timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ArbIdle;
      grant_idx <= '0;
      rr_ptr    <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt       <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt       <= cnt_nxt;
      tmo_q     <= tmo_nxt;
`endif
    end
  end

  // Next-state logic: arbitrate from IDLE/TURN, release (or time out) from GRANT.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_idx;
    rr_ptr_nxt = rr_ptr;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_nxt    = cnt;
    tmo_nxt    = 1'b0;
`endif
    case (state)
      ArbIdle, ArbTurn: begin
        if (pick_vld) begin
          state_nxt = ArbGrant;
          grant_nxt = pick_idx;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end else begin
          state_nxt = ArbIdle;
        end
      end
      ArbGrant: begin
        // Always pass through TURN so two agents never drive the bus together.
        if (!req_in[grant_idx]) begin
          state_nxt  = ArbTurn;
          rr_ptr_nxt = ptr_after_owner;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt  = ArbTurn;
          rr_ptr_nxt = ptr_after_owner;
          tmo_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      default: state_nxt = ArbIdle;
    endcase
  end

  // Output decode: selects only in GRANT, holds for every requester that is not the owner.
  always_comb begin
    master_select_as_out = '0;
    slave_select_as_out  = '0;
    hold_flag_out        = '0;
    bus_busy_out         = (state == ArbGrant);
    grant_idx_out        = grant_idx;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      master_select_as_out[i] = SelectAsNone;
      if (state == ArbGrant && grant_idx == IDX_W'(i)) begin
        master_select_as_out[i] = SelectAsMaster;
      end
      // Gated by rst so losers are released while reset is held.
      hold_flag_out[i] = req_in[i] & ~rst & ~(state == ArbGrant && grant_idx == IDX_W'(i));
    end
    for (int j = 0; j < NUM_SLAVES; j++) begin
      slave_select_as_out[j] = SelectAsNone;
      if (state == ArbGrant && slave_idx == SLAVE_SEL_BITS'(j)) begin
        slave_select_as_out[j] = SelectAsDevice;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout_out = tmo_q;
`else
  assign timeout_out = 1'b0;
`endif

endmodule
